cache_tag_engine: RTL and testbench

CACHE_TAG_ENGINE -- requirements
Module: cache_tag_engine

---
 rtl/cache_pkg.sv | 47 ++++
 rtl/cache_set_lookup.sv | 46 ++++
 rtl/cache_tag_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_tag_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared encodings and width helpers for the cache tag engine.
package cache_pkg;

   // Replacement policy encoding on the replace_policy pin
   typedef enum logic {
      REPL_FIFO = 1'b0,
      REPL_LRU  = 1'b1
   } repl_t;

   // Write policy encoding on the write_policy pin
   typedef enum logic {
      WR_BACK    = 1'b0,   // write-back, write-allocate
      WR_THROUGH = 1'b1    // write-through, no-write-allocate
   } wpol_t;

   // Request sequencing: one cycle per state
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_UPDATE = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Statistics counter slots
   localparam int CNT_RD    = 0;
   localparam int CNT_WR    = 1;
   localparam int CNT_RD_MS = 2;
   localparam int CNT_WR_MS = 3;
   localparam int CNT_WB    = 4;
   localparam int NUM_CNT   = 5;

   // Byte-offset bits within a line
   function automatic int offset_w(input int block_bytes);
      return $clog2(block_bytes);
   endfunction

   // Set-index bits
   function automatic int index_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   // Age bits per way (also the width of a way number)
   function automatic int age_w(input int assoc);
      return $clog2(assoc);
   endfunction

endpackage

// File: rtl/cache_set_lookup.sv
// Combinational parallel tag compare and victim selection for one set.
module cache_set_lookup
   import cache_pkg::*;
#(
   parameter int ASSOC = 8,
   parameter int TAG_W = 36,
   parameter int AGE_W = 3
) (
   input  logic [ASSOC-1:0]            way_valid,
   input  logic [ASSOC-1:0][TAG_W-1:0] way_tag,
   input  logic [ASSOC-1:0][AGE_W-1:0] way_age,
   input  logic [TAG_W-1:0]            lookup_tag,
   output logic                        hit,
   output logic [AGE_W-1:0]            hit_way,
   output logic [AGE_W-1:0]            victim_way
);

   logic [ASSOC-1:0] match;
   logic [ASSOC-1:0] is_oldest;

   for (genvar gi = 0; gi < ASSOC; gi++) begin : g_cmp
      assign match[gi]     = way_valid[gi] && (way_tag[gi] == lookup_tag);
      assign is_oldest[gi] = (way_age[gi] == AGE_W'(ASSOC - 1));
   end

   // Encode hit way; victim is the lowest free way, else the oldest way
   always_comb begin
      hit        = |match;
      hit_way    = '0;
      victim_way = '0;
      // Descending scans so the lowest-numbered candidate wins
      for (int i = ASSOC - 1; i >= 0; i--) begin
         if (match[i]) hit_way = AGE_W'(i);
      end
      if (&way_valid) begin
         for (int i = ASSOC - 1; i >= 0; i--) begin
            if (is_oldest[i]) victim_way = AGE_W'(i);
         end
      end else begin
         for (int i = ASSOC - 1; i >= 0; i--) begin
            if (!way_valid[i]) victim_way = AGE_W'(i);
         end
      end
   end

endmodule

// File: rtl/cache_tag_engine.sv
// Set-associative cache tag engine with FIFO/LRU replacement and statistics.
module cache_tag_engine
   import cache_pkg::*;
#(
   parameter int ADDR_W      = 48,
   parameter int BLOCK_BYTES = 64,
   parameter int NUM_SETS    = 64,
   parameter int ASSOC       = 8,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   input  logic              replace_policy,
   input  logic              write_policy,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic              resp_evict,
   output logic              resp_evict_dirty,
   output logic [ADDR_W-1:0] resp_evict_tag,
   output logic [CNT_W-1:0]  num_reads,
   output logic [CNT_W-1:0]  num_writes,
   output logic [CNT_W-1:0]  num_read_misses,
   output logic [CNT_W-1:0]  num_write_misses,
   output logic [CNT_W-1:0]  num_writebacks
);

   localparam int OFF_W  = offset_w(BLOCK_BYTES);
   localparam int IDX_W  = index_w(NUM_SETS);
   localparam int AGE_W  = age_w(ASSOC);
   localparam int LINE_W = ADDR_W - OFF_W;
   localparam int TAG_W  = LINE_W - IDX_W;

   // Per-set way state
   logic [ASSOC-1:0]            valid_reg [NUM_SETS];
   logic [ASSOC-1:0]            dirty_reg [NUM_SETS];
   logic [ASSOC-1:0][TAG_W-1:0] tag_reg   [NUM_SETS];
   logic [ASSOC-1:0][AGE_W-1:0] age_reg   [NUM_SETS];

   // Captured request
   state_t            state_reg;
   logic [LINE_W-1:0] line_reg;
   logic              write_reg;
   repl_t             repl_reg;
   wpol_t             wpol_reg;
   logic              req_ready_reg;

   // Lookup results held for the update cycle
   logic              hit_reg;
   logic [AGE_W-1:0]  hit_way_reg;
   logic [AGE_W-1:0]  victim_reg;

   logic              resp_valid_reg, resp_hit_reg, resp_evict_reg, resp_dirty_reg;
   logic [ADDR_W-1:0] resp_tag_reg;

   logic [IDX_W-1:0]            idx;
   logic [TAG_W-1:0]            tag;
   logic [ASSOC-1:0]            cur_valid, cur_dirty, nxt_valid, nxt_dirty;
   logic [ASSOC-1:0][TAG_W-1:0] cur_tag, nxt_tag;
   logic [ASSOC-1:0][AGE_W-1:0] cur_age, nxt_age;
   logic                        lk_hit;
   logic [AGE_W-1:0]            lk_hit_way, lk_victim;
   logic [AGE_W-1:0]            hit_age;
   logic                        do_fill, evict, evict_dirty;
   logic [NUM_CNT-1:0]          cnt_inc;
   logic [CNT_W-1:0]            cnt_all [NUM_CNT];
   logic                        unused_offset;

   // The byte offset never matters to the tag store
   assign unused_offset = ^req_addr[OFF_W-1:0];

   assign idx       = line_reg[IDX_W-1:0];
   assign tag       = line_reg[IDX_W +: TAG_W];
   assign cur_valid = valid_reg[idx];
   assign cur_dirty = dirty_reg[idx];
   assign cur_tag   = tag_reg[idx];
   assign cur_age   = age_reg[idx];

   cache_set_lookup #(
      .ASSOC (ASSOC),
      .TAG_W (TAG_W),
      .AGE_W (AGE_W)
   ) u_lookup (
      .way_valid  (cur_valid),
      .way_tag    (cur_tag),
      .way_age    (cur_age),
      .lookup_tag (tag),
      .hit        (lk_hit),
      .hit_way    (lk_hit_way),
      .victim_way (lk_victim)
   );

   // Next contents of the addressed set, applied in the update cycle
   always_comb begin
      nxt_valid   = cur_valid;
      nxt_dirty   = cur_dirty;
      nxt_tag     = cur_tag;
      nxt_age     = cur_age;
      hit_age     = cur_age[hit_way_reg];
      // A write miss under write-through leaves the set untouched
      do_fill     = !hit_reg && !(write_reg && (wpol_reg == WR_THROUGH));
      evict       = do_fill && cur_valid[victim_reg];
      evict_dirty = evict && cur_dirty[victim_reg];
      if (hit_reg) begin
         if (write_reg && (wpol_reg == WR_BACK)) nxt_dirty[hit_way_reg] = 1'b1;
         if (repl_reg == REPL_LRU) begin
            for (int i = 0; i < ASSOC; i++) begin
               if (cur_valid[i] && (cur_age[i] < hit_age)) nxt_age[i] = cur_age[i] + AGE_W'(1);
            end
            nxt_age[hit_way_reg] = '0;
         end
      end else if (do_fill) begin
         for (int i = 0; i < ASSOC; i++) begin
            if (cur_valid[i]) nxt_age[i] = cur_age[i] + AGE_W'(1);
         end
         nxt_valid[victim_reg] = 1'b1;
         nxt_dirty[victim_reg] = write_reg;
         nxt_tag[victim_reg]   = tag;
         nxt_age[victim_reg]   = '0;
      end
   end

   // Request FSM with registered handshake and response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         req_ready_reg  <= 1'b1;
         line_reg       <= '0;
         write_reg      <= 1'b0;
         repl_reg       <= REPL_FIFO;
         wpol_reg       <= WR_BACK;
         hit_reg        <= 1'b0;
         hit_way_reg    <= '0;
         victim_reg     <= '0;
         resp_valid_reg <= 1'b0;
         resp_hit_reg   <= 1'b0;
         resp_evict_reg <= 1'b0;
         resp_dirty_reg <= 1'b0;
         resp_tag_reg   <= '0;
      end else begin
         resp_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  line_reg      <= req_addr[ADDR_W-1:OFF_W];
                  write_reg     <= req_write;
                  repl_reg      <= repl_t'(replace_policy);
                  wpol_reg      <= wpol_t'(write_policy);
                  req_ready_reg <= 1'b0;
                  state_reg     <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               hit_reg     <= lk_hit;
               hit_way_reg <= lk_hit_way;
               victim_reg  <= lk_victim;
               state_reg   <= ST_UPDATE;
            end
            ST_UPDATE: begin
               resp_valid_reg <= 1'b1;
               resp_hit_reg   <= hit_reg;
               resp_evict_reg <= evict;
               resp_dirty_reg <= evict_dirty;
               resp_tag_reg   <= evict ? ADDR_W'(cur_tag[victim_reg]) : '0;
               state_reg      <= ST_RESP;
            end
            default: begin
               req_ready_reg <= 1'b1;
               state_reg     <= ST_IDLE;
            end
         endcase
      end
   end

   // Tag store: cleared on reset, written once per request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_reg[s] <= '0;
            dirty_reg[s] <= '0;
            tag_reg[s]   <= '0;
            age_reg[s]   <= '0;
         end
      end else if (state_reg == ST_UPDATE) begin
         valid_reg[idx] <= nxt_valid;
         dirty_reg[idx] <= nxt_dirty;
         tag_reg[idx]   <= nxt_tag;
         age_reg[idx]   <= nxt_age;
      end
   end

   always_comb begin
      cnt_inc            = '0;
      cnt_inc[CNT_RD]    = !write_reg;
      cnt_inc[CNT_WR]    = write_reg;
      cnt_inc[CNT_RD_MS] = !write_reg && !hit_reg;
      cnt_inc[CNT_WR_MS] = write_reg && !hit_reg;
      cnt_inc[CNT_WB]    = evict_dirty;
   end

   for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      // Saturating statistics counter, bumped in the update cycle
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_reg <= '0;
         end else if ((state_reg == ST_UPDATE) && cnt_inc[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
      assign cnt_all[gi] = cnt_reg;
   end

   assign req_ready        = req_ready_reg;
   assign resp_valid       = resp_valid_reg;
   assign resp_hit         = resp_hit_reg;
   assign resp_evict       = resp_evict_reg;
   assign resp_evict_dirty = resp_dirty_reg;
   assign resp_evict_tag   = resp_tag_reg;
   assign num_reads        = cnt_all[CNT_RD];
   assign num_writes       = cnt_all[CNT_WR];
   assign num_read_misses  = cnt_all[CNT_RD_MS];
   assign num_write_misses = cnt_all[CNT_WR_MS];
   assign num_writebacks   = cnt_all[CNT_WB];

endmodule

// File: tb/tb_cache_tag_engine.sv
// Scoreboard bench for cache_tag_engine: directed sequences, decoupled monitor.
module tb_cache_tag_engine;

   localparam int AW = 48;
   localparam int CW = 4;   // narrow counters so saturation is reachable

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          req_write = 1'b0;
   logic          replace_policy = 1'b0;
   logic          write_policy = 1'b0;
   logic          resp_valid, resp_hit, resp_evict, resp_evict_dirty;
   logic [AW-1:0] resp_evict_tag;
   logic [CW-1:0] num_reads, num_writes, num_read_misses, num_write_misses, num_writebacks;

   cache_tag_engine #(
      .ADDR_W      (AW),
      .BLOCK_BYTES (64),
      .NUM_SETS    (64),
      .ASSOC       (8),
      .CNT_W       (CW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_addr         (req_addr),
      .req_write        (req_write),
      .replace_policy   (replace_policy),
      .write_policy     (write_policy),
      .resp_valid       (resp_valid),
      .resp_hit         (resp_hit),
      .resp_evict       (resp_evict),
      .resp_evict_dirty (resp_evict_dirty),
      .resp_evict_tag   (resp_evict_tag),
      .num_reads        (num_reads),
      .num_writes       (num_writes),
      .num_read_misses  (num_read_misses),
      .num_write_misses (num_write_misses),
      .num_writebacks   (num_writebacks)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      bit            hit;
      bit            evict;
      bit            dirty;
      logic [AW-1:0] tag;
      int            acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cycle_cnt = 0;

   always @(posedge clk) cycle_cnt++;

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every response pulse pops and checks one expectation
   always @(negedge clk) begin
      if (!reset && resp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_hit", AW'(resp_hit), AW'(e.hit));
            check("resp_evict", AW'(resp_evict), AW'(e.evict));
            check("resp_evict_dirty", AW'(resp_evict_dirty), AW'(e.dirty));
            check("resp_evict_tag", resp_evict_tag, e.tag);
            check("resp_latency", AW'(cycle_cnt - e.acc), AW'(2));
            $display("resp addr=0x%0h hit=%0b evict=%0b dirty=%0b tag=0x%0h", e.addr,
                     resp_hit, resp_evict, resp_evict_dirty, resp_evict_tag);
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) return;
      end
      checks++;
      failures++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && req_ready) return;
      end
      checks++;
      failures++;
      $display("FAIL idle_timeout: got %0d pending responses expected 0", sb.size());
   endtask

   // Issue one request; after acceptance scramble the inputs to show capture
   task automatic do_req(input logic [AW-1:0] a, input bit wr, input bit rp, input bit wp,
                         input bit eh, input bit ee, input bit ed, input logic [AW-1:0] et);
      exp_t e;
      wait_ready();
      req_valid      = 1'b1;
      req_addr       = a;
      req_write      = wr;
      replace_policy = rp;
      write_policy   = wp;
      @(posedge clk);
      @(negedge clk);
      req_valid      = 1'b0;
      req_write      = ~wr;
      replace_policy = ~rp;
      write_policy   = ~wp;
      req_addr       = a ^ AW'(48'h5000);
      e.addr = a; e.hit = eh; e.evict = ee; e.dirty = ed; e.tag = et; e.acc = cycle_cnt;
      sb.push_back(e);
   endtask

   task automatic check_counters(input string tag, input int rd, input int wr, input int rm,
                                 input int wm, input int wb);
      check({tag, ".num_reads"}, AW'(num_reads), AW'(rd));
      check({tag, ".num_writes"}, AW'(num_writes), AW'(wr));
      check({tag, ".num_read_misses"}, AW'(num_read_misses), AW'(rm));
      check({tag, ".num_write_misses"}, AW'(num_write_misses), AW'(wm));
      check({tag, ".num_writebacks"}, AW'(num_writebacks), AW'(wb));
   endtask

   // Eight reads filling set 0, one hit on tag 0, then a conflicting miss
   task automatic fill_hit_evict(input bit rp, input logic [AW-1:0] evtag);
      for (int i = 0; i < 8; i++) do_req(AW'(i * 32'h1000), 1'b0, rp, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      do_req(AW'(0), 1'b0, rp, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      do_req(AW'(48'h8000), 1'b0, rp, 1'b0, 1'b0, 1'b1, 1'b0, evtag);
      wait_idle();
   endtask

   initial begin
      apply_reset();
      @(negedge clk);
      check("reset.req_ready", AW'(req_ready), AW'(1));
      check("reset.resp_valid", AW'(resp_valid), AW'(0));
      check("reset.resp_evict_tag", resp_evict_tag, '0);
      check_counters("reset", 0, 0, 0, 0, 0);

      // Miss then hit on the same line
      do_req(AW'(48'h40), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      do_req(AW'(48'h40), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      wait_idle();
      check_counters("readtwice", 2, 0, 1, 0, 0);
      repeat (3) @(negedge clk);
      check("resp_hold.resp_hit", AW'(resp_hit), AW'(1));

      // FIFO keeps the first-filled line oldest despite the hit
      apply_reset();
      fill_hit_evict(1'b0, AW'(0));
      check_counters("fifo", 10, 0, 9, 0, 0);

      // LRU refreshes tag 0, so tag 1 becomes the victim
      apply_reset();
      fill_hit_evict(1'b1, AW'(1));
      check_counters("lru", 10, 0, 9, 0, 0);

      // Write-back: dirty line 0 is evicted by the ninth distinct tag
      apply_reset();
      do_req(AW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 1; i < 8; i++) do_req(AW'(i * 32'h1000), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      do_req(AW'(48'h8000), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, AW'(0));
      wait_idle();
      check_counters("wb", 8, 1, 8, 1, 1);

      // Write-through write miss allocates nothing
      apply_reset();
      do_req(AW'(48'h2000), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      do_req(AW'(48'h2000), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_idle();
      check_counters("wt_miss", 1, 1, 1, 1, 0);

      // Write-through write hit leaves the line clean
      apply_reset();
      do_req(AW'(0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      do_req(AW'(0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 1; i < 8; i++) do_req(AW'(i * 32'h1000), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      do_req(AW'(48'h8000), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(0));
      wait_idle();
      check_counters("wt_hit", 9, 1, 9, 0, 0);

      // Counters saturate at all-ones
      apply_reset();
      do_req(AW'(48'h40), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 17; i++) do_req(AW'(48'h40), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      wait_idle();
      check_counters("saturate", 15, 0, 1, 0, 0);

      // Reset asserted during the update cycle abandons the request
      apply_reset();
      wait_ready();
      req_valid = 1'b1;
      req_addr  = AW'(48'h80);
      req_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midreset.req_ready", AW'(req_ready), AW'(1));
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen = 1'b1;
            @(negedge clk);
         end
         check("midreset.resp_valid_seen", AW'(seen), AW'(0));
      end
      check_counters("midreset", 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion expected finish before 500000");
      $fatal(1, "timeout");
   end

endmodule
